lcd_write_engine: RTL and testbench
===================================

LCD_WRITE_ENGINE -- requirements
Module: lcd_write_engine

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 500: lcd_en high time in clk_1MHz cycles (legal range 1..65535).
REQ-002 SHALL have parameter GAP_CYCLES, default 500: lcd_en low time after each pulse (legal range 1..65535).
REQ-003 SHALL have parameter INIT_WAIT, default 15000: power-up wait before the first command.
REQ-004 SHALL have parameter CLEAR_WAIT, default 2000: extra low time after the clear command (0x01).
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 Port clk_1MHz  in  1  1 MHz system clock; all logic is on its rising edge.
REQ-007 Port rst  in  1  asynchronous active-low reset.
REQ-008 Port req_valid  in  1  requester has a byte to write.
REQ-009 Port req_rs  in  1  0 = command, 1 = character data.
REQ-010 Port req_data  in  8  byte to write.
REQ-011 Port req_ready  out  1  engine accepts a byte this cycle.
REQ-012 Port init_done  out  1  power-up command sequence completed.
REQ-013 Port busy  out  1  high whenever the state is not IDLE.
REQ-014 Ports lcd_rs, lcd_rw, lcd_en (out, 1 bit each) and lcd_data (out, 8 bits) SHALL drive the character LCD in 8-bit parallel mode.

Function
REQ-015 States SHALL be: PWR_WAIT, INIT_SETUP, INIT_HI, INIT_LO, IDLE, SETUP, EN_HI, EN_LO.
REQ-016 After reset release, the engine SHALL stay in PWR_WAIT for INIT_WAIT cycles with lcd_en=0.
REQ-017 The init sequence SHALL send 0x38, 0x0C, 0x01, 0x06 in order, all with rs=0.
REQ-018 Each init byte SHALL use the same SETUP/HI/LO timing as a requested byte.
REQ-019 The LO phase after 0x01 SHALL last GAP_CYCLES+CLEAR_WAIT cycles.
REQ-020 init_done SHALL rise on the cycle the engine first enters IDLE and stay high until reset.
REQ-021 req_ready SHALL be high only in IDLE with init_done=1, and SHALL be a registered output.
REQ-022 A handshake occurs at rising edge T when req_valid=1 and req_ready=1; req_rs and req_data SHALL be captured at that edge.
REQ-023 From T+1 (SETUP, 1 cycle): lcd_rs and lcd_data SHALL show the captured values, lcd_en=0, req_ready=0.
REQ-024 lcd_en SHALL be 1 from T+2 for exactly HOLD_CYCLES cycles, then 0 for GAP_CYCLES cycles.
REQ-025 The engine SHALL return to IDLE with req_ready=1 at T+2+HOLD_CYCLES+GAP_CYCLES.
REQ-026 lcd_rs and lcd_data SHALL hold stable from SETUP until the next SETUP.
REQ-027 Input changes after T SHALL NOT affect the transfer in progress.
REQ-028 req_valid while req_ready=0 SHALL be ignored, with no capture; the requester holds its request.
REQ-029 With req_valid held high, the next byte SHALL be accepted on the first IDLE cycle, with no extra idle cycle.
REQ-030 lcd_rw SHALL be 0 at all times (write-only).
REQ-031 The phase counter SHALL be 16-bit unsigned, cleared on every state change, and SHALL never wrap within legal parameters.

Reset
REQ-032 While rst=0: state=PWR_WAIT, counter=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, req_ready=0, init_done=0, busy=1.
REQ-033 Reset asserted mid-pulse SHALL force lcd_en=0 immediately, without a clock edge.
REQ-034 After reset is released, the engine SHALL restart the full power-up sequence from PWR_WAIT.

Structure
REQ-035 Package lcd_pkg SHALL hold the state encoding, the command constants (FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY 0x06) and the default timing values.
REQ-036 One sub-module, lcd_phase_timer (load/count/done), SHALL be instantiated for all phase timing.
REQ-037 The init sequence SHALL be a 2-bit index into the package command constants.

Verification (INIT_WAIT=10, HOLD_CYCLES=3, GAP_CYCLES=3, CLEAR_WAIT=5)
REQ-038 Release reset -> lcd_en=0 for 10 cycles; then 4 pulses (0x38, 0x0C, 0x01, 0x06, rs=0) of 3 cycles high each; the low gap after 0x01 is 8 cycles; init_done=1 and req_ready=1 on entering IDLE.
REQ-039 Handshake at T with rs=1, data=0x42 -> at T+1 lcd_data=0x42, lcd_rs=1, lcd_en=0; lcd_en=1 during T+2..T+4; lcd_en=0 during T+5..T+7; req_ready=1 at T+8.
REQ-040 req_valid held high with 0x42 then 0x75 (data changed at T+3) -> lcd_data stays 0x42 until the second SETUP; the second handshake occurs at T+8.
REQ-041 req_valid=1 during the init sequence -> no handshake, req_ready=0, lcd_data carries only init bytes.
REQ-042 rst driven low in the middle of EN_HI -> lcd_en=0 asynchronously and all outputs take their reset values; after release, 10 wait cycles then 0x38 is sent again.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, HD44780 init commands and default timing for the LCD write engine.
package lcd_pkg;
  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_SETUP,
    INIT_HI,
    INIT_LO,
    IDLE,
    SETUP,
    EN_HI,
    EN_LO
  } state_e;
  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON = 8'h0C;
  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] ENTRY = 8'h06;
  localparam logic [1:0] CLEAR_IDX = 2'd2;
  localparam int DEF_HOLD_CYCLES = 500;
  localparam int DEF_GAP_CYCLES = 500;
  localparam int DEF_INIT_WAIT = 15000;
  localparam int DEF_CLEAR_WAIT = 2000;
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    return i == 2'd0 ? FUNC_SET : i == 2'd1 ? DISP_ON : i == 2'd2 ? CLEAR : ENTRY;
  endfunction
endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: 16-bit phase counter, cleared on load, done when it reaches the phase's last count.
module lcd_phase_timer (
  input  logic        clk_1MHz,
  input  logic        rst,
  input  logic        load_i,
  input  logic        count_i,
  input  logic [15:0] last_i,
  output logic        done_o
);
  logic [15:0] cnt_q;
  always_ff @(posedge clk_1MHz or negedge rst)
    if (!rst) cnt_q <= '0;
    else if (load_i) cnt_q <= '0;
    else if (count_i) cnt_q <= cnt_q + 16'd1;
  assign done_o = cnt_q == last_i;
endmodule

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: powers up a character LCD in 8-bit mode, then writes requested bytes with timed lcd_en pulses.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int INIT_WAIT   = DEF_INIT_WAIT,
  parameter int CLEAR_WAIT  = DEF_CLEAR_WAIT
) (
  input  logic       clk_1MHz,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);
  localparam logic [15:0] WAIT_LAST = 16'(INIT_WAIT - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] CLR_LAST = 16'(GAP_CYCLES + CLEAR_WAIT - 1);
  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        rs_q, rs_d, en_d, ready_d, done_d_q, init_done_d;
  logic [7:0]  data_q, data_d;
  logic        en_q, ready_q;
  logic [15:0] last;
  logic        phase_done;
  assign last = state_q == PWR_WAIT ? WAIT_LAST :
                (state_q == INIT_HI || state_q == EN_HI) ? HOLD_LAST :
                (state_q == INIT_LO && idx_q == CLEAR_IDX) ? CLR_LAST :
                (state_q == INIT_LO || state_q == EN_LO) ? GAP_LAST : 16'd0;
  lcd_phase_timer u_timer (
    .clk_1MHz(clk_1MHz),
    .rst     (rst),
    .load_i  (state_d != state_q),
    .count_i (state_q != IDLE),
    .last_i  (last),
    .done_o  (phase_done)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rs_d = rs_q;
    data_d = data_q;
    case (state_q)
      PWR_WAIT:   state_d = phase_done ? INIT_SETUP : PWR_WAIT;
      INIT_SETUP: state_d = phase_done ? INIT_HI : INIT_SETUP;
      INIT_HI:    state_d = phase_done ? INIT_LO : INIT_HI;
      INIT_LO:
        if (phase_done) begin
          state_d = idx_q == 2'd3 ? IDLE : INIT_SETUP;
          idx_d = idx_q + 2'd1;
        end
      IDLE:       state_d = (req_valid && ready_q) ? SETUP : IDLE;
      SETUP:      state_d = phase_done ? EN_HI : SETUP;
      EN_HI:      state_d = phase_done ? EN_LO : EN_HI;
      EN_LO:      state_d = phase_done ? IDLE : EN_LO;
      default:    state_d = PWR_WAIT;
    endcase
    // rs/data are latched only on entry to a setup phase so they hold until the next one
    if (state_d == INIT_SETUP && state_q != INIT_SETUP) begin
      rs_d = 1'b0;
      data_d = init_cmd(idx_d);
    end
    if (state_d == SETUP && state_q != SETUP) begin
      rs_d = req_rs;
      data_d = req_data;
    end
    en_d = state_d == INIT_HI || state_d == EN_HI;
    init_done_d = done_d_q || state_d == IDLE;
    ready_d = state_d == IDLE && init_done_d;
  end
  always_ff @(posedge clk_1MHz or negedge rst)
    if (!rst) begin
      state_q <= PWR_WAIT;
      idx_q <= '0;
      rs_q <= 1'b0;
      data_q <= '0;
      en_q <= 1'b0;
      ready_q <= 1'b0;
      done_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rs_q <= rs_d;
      data_q <= data_d;
      en_q <= en_d;
      ready_q <= ready_d;
      done_d_q <= init_done_d;
    end
  assign req_ready = ready_q;
  assign init_done = done_d_q;
  assign busy = state_q != IDLE;
  assign lcd_rs = rs_q;
  assign lcd_rw = 1'b0;
  assign lcd_en = en_q;
  assign lcd_data = data_q;
endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: scoreboard bench; expected bytes are queued when driven and popped on each lcd_en rise.
module tb_lcd_write_engine;
  localparam int INIT_WAIT = 10;
  localparam int HOLD = 3;
  localparam int GAP = 3;
  localparam int CLR = 5;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
  int         n_pass = 0;
  int         n_total = 0;
  logic [8:0] sb[$];
  int         lo_runs[$];
  logic       prev_en = 1'b0;
  int         hi_n = 0;
  int         lo_n = 0;
  logic [8:0] cur = '0;
  lcd_write_engine #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .INIT_WAIT  (INIT_WAIT),
    .CLEAR_WAIT (CLR)
  ) dut (
    .clk_1MHz (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_rs   (req_rs),
    .req_data (req_data),
    .req_ready(req_ready),
    .init_done(init_done),
    .busy     (busy),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic drive(input logic rs, input logic [7:0] d);
    req_valid = 1'b1;
    req_rs = rs;
    req_data = d;
    sb.push_back({rs, d});
  endtask
  task automatic push_init();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h06});
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_en"}, lcd_en, 0);
    chk({p, "_rs"}, lcd_rs, 0);
    chk({p, "_rw"}, lcd_rw, 0);
    chk({p, "_data"}, lcd_data, 0);
    chk({p, "_ready"}, req_ready, 0);
    chk({p, "_init_done"}, init_done, 0);
    chk({p, "_busy"}, busy, 1);
  endtask
  task automatic power_up();
    int n;
    logic early;
    n = 0;
    while (!lcd_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pwr_wait", n, INIT_WAIT + 1);
    n = 0;
    early = 1'b0;
    while (!init_done && n < 500) begin
      early |= req_ready;
      @(negedge clk);
      n++;
    end
    chk("init_len", n, 4 * (HOLD + GAP) + CLR + 3);
    chk("init_ready", req_ready, 1);
    chk("init_early_ready", early, 0);
    chk("init_busy", busy, 0);
  endtask
  task automatic xfer(input logic rs, input logic [7:0] d, input logic hold, input logic nrs,
                      input logic [7:0] nd, output int w);
    logic [7:1] env;
    w = 0;
    while (!req_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("ready_timeout", req_ready, 1);
      return;
    end
    env = '0;
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      if (s <= 7) env = {lcd_en, env[7:2]};
      if (s == 1) begin
        chk("setup_data", lcd_data, d);
        chk("setup_rs", lcd_rs, rs);
        chk("setup_en", lcd_en, 0);
        chk("setup_ready", req_ready, 0);
        chk("setup_busy", busy, 1);
        if (!hold) req_valid = 1'b0;
      end
      if (s == 3 && hold) drive(nrs, nd);
      if (s == 4) chk("hold_data", lcd_data, d);
      if (s == 8) chk("ret_ready", req_ready, 1);
    end
    chk("en_pattern", env, 7'b0001110);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      prev_en = 1'b0;
      hi_n = 0;
      lo_n = 0;
    end else if (lcd_en) begin
      if (!prev_en) begin
        lo_runs.push_back(lo_n);
        lo_n = 0;
        if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
        else begin
          cur = sb.pop_front();
          chk("pulse_rs", lcd_rs, cur[8]);
          chk("pulse_data", lcd_data, cur[7:0]);
          chk("pulse_rw", lcd_rw, 0);
        end
      end
      hi_n++;
      prev_en = 1'b1;
    end else begin
      if (prev_en) begin
        chk("hi_len", hi_n, HOLD);
        chk("fall_data", lcd_data, cur[7:0]);
      end
      hi_n = 0;
      lo_n++;
      prev_en = 1'b0;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int w, n;
    logic [7:0] d;
    logic r;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    push_init();
    drive(1'b1, 8'h99);
    rst = 1'b1;
    power_up();
    xfer(1'b1, 8'h99, 1'b0, 1'b0, 8'h00, w);
    chk("first_wait", w, 0);
    chk("lo_run_0c", lo_runs[1], GAP + 1);
    chk("lo_run_01", lo_runs[2], GAP + 1);
    chk("lo_run_06_clear", lo_runs[3], GAP + CLR + 1);
    chk("lo_run_first_req", lo_runs[4], GAP + 2);
    repeat (2) @(negedge clk);
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    drive(1'b1, 8'h42);
    xfer(1'b1, 8'h42, 1'b1, 1'b0, 8'h75, w);
    xfer(1'b0, 8'h75, 1'b0, 1'b0, 8'h00, w);
    chk("b2b_wait", w, 0);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      r = 1'($urandom_range(0, 1));
      drive(r, d);
      xfer(r, d, 1'b0, 1'b0, 8'h00, w);
      repeat (i + 1) @(negedge clk);
      chk("rand_idle_ready", req_ready, 1);
    end
    drive(1'b1, 8'h33);
    n = 0;
    while (!lcd_en && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_en_seen", lcd_en, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk_reset("arst");
    push_init();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    power_up();
    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
